// File: rtl/fifo_pkg.sv
// Shared constants, count-width helper and bundled status type for the single-clock FIFO.
package fifo_pkg;

    localparam int FIFO_DEF_DATA_W = 8;
    localparam int FIFO_DEF_DEPTH  = 16;

    // Occupancy must represent 0..depth inclusive, hence one bit beyond the address width.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
module sync_fifo_mem import fifo_pkg::*; #(
    parameter int DATA_W = FIFO_DEF_DATA_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags and read port.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_ctrl import fifo_pkg::*; #(
    parameter int DATA_W    = FIFO_DEF_DATA_W,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             din,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             dout,
    output logic                          valid,
    output logic                          empty,
    output logic                          almost_empty,
    output logic                          underflow,
    output logic [fifo_cnt_w(DEPTH)-1:0]  data_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = fifo_cnt_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    fifo_status_t      status_reg;
    fifo_status_t      status_next;
    logic [DATA_W-1:0] mem_rd_data;
    logic              wr_acc;
    logic              rd_acc;

    // Flags are computed from the next count so they land together with it.
    always_comb begin
        wr_acc     = wr_en && !status_reg.full;
        rd_acc     = rd_en && !status_reg.empty;
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CNT_W'(1);
        end
        status_next.full         = (count_next == CNT_W'(DEPTH));
        status_next.almost_full  = (count_next >= CNT_W'(AF_THRESH));
        status_next.empty        = (count_next == '0);
        status_next.almost_empty = (count_next <= CNT_W'(AE_THRESH));
        status_next.overflow     = wr_en && status_reg.full;
        status_next.underflow    = rd_en && status_reg.empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            status_reg <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1,
                            almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg  <= count_next;
            status_reg <= status_next;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_reg),
        .wr_data (din),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rd_data)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout  = mem_rd_data;
    assign valid = !status_reg.empty;
`else
    logic [DATA_W-1:0] dout_reg;
    logic              valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_acc;
            if (rd_acc) begin
                dout_reg <= mem_rd_data;
            end
        end
    end

    assign dout  = dout_reg;
    assign valid = valid_reg;
`endif

    assign full         = status_reg.full;
    assign almost_full  = status_reg.almost_full;
    assign empty        = status_reg.empty;
    assign almost_empty = status_reg.almost_empty;
    assign overflow     = status_reg.overflow;
    assign underflow    = status_reg.underflow;
    assign data_count   = count_reg;

endmodule
